// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4:1 mux round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      SWITCH = 2'd2
   } arb_state_t;

   // One-hot grant vector for a requester index.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
      return NUM_REQ'(1) << i;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick: first requesting index scanning from ptr upward, mod 4.
// Latency: combinational.
// Backpressure: none; ports req[3:0], ptr[1:0] in; idx[1:0], any out.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);

   logic [SEL_W-1:0] cand;
   logic             found;

   always_comb begin
      idx   = ptr;
      cand  = ptr;
      found = 1'b0;
      any   = |req;
      for (int k = 0; k < NUM_REQ; k++) begin
         // 2-bit add wraps naturally, giving the mod-4 scan order
         cand = ptr + SEL_W'(k);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selectors, with bounded hold and a one-cycle break-before-make gap.
// Latency: grant 1 cycle after request; f/valid 1 cycle after each GRANT cycle.
// Backpressure: none; ports clk, rst, req[3:0], w[3:0] in; gnt[3:0], s1, s0, f, valid, busy out (all registered).
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] w,
   output logic [NUM_REQ-1:0] gnt,
   output logic               s1,
   output logic               s0,
   output logic               f,
   output logic               valid,
   output logic               busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t         state, state_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [SEL_W-1:0]   sel, sel_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic               f_nxt, valid_nxt, busy_nxt;

   logic [SEL_W-1:0]   pick_idx;
   logic               pick_any;
   logic [NUM_REQ-1:0] others;
   logic               hold_done;
   logic               rel_now;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // The granted index lives in the selector register itself.
   assign s1 = sel[1];
   assign s0 = sel[0];

   assign others    = req & ~onehot(sel);
   assign hold_done = (cnt == HOLD_LAST);
   // A drop and an expiry in the same cycle collapse into this single release.
   assign rel_now   = (state == GRANT) && (!req[sel] || (hold_done && (others != '0)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         sel   <= '0;
         gnt   <= '0;
         f     <= 1'b0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         sel   <= sel_nxt;
         gnt   <= gnt_nxt;
         f     <= f_nxt;
         valid <= valid_nxt;
         busy  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      sel_nxt   = sel;
      gnt_nxt   = gnt;
      f_nxt     = f;
      valid_nxt = valid;
      busy_nxt  = busy;
      case (state)
         IDLE: begin
            valid_nxt = 1'b0;
            if (pick_any) begin
               state_nxt = GRANT;
               gnt_nxt   = onehot(pick_idx);
               sel_nxt   = pick_idx;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
            end
         end
         GRANT: begin
            f_nxt = w[sel];
            if (rel_now) begin
               state_nxt = SWITCH;
               gnt_nxt   = '0;
               valid_nxt = 1'b0;
               ptr_nxt   = sel + SEL_W'(1);
            end else begin
               valid_nxt = 1'b1;
               // Saturates at the limit: a lone requester keeps the mux indefinitely.
               if (!hold_done) cnt_nxt = cnt + CNT_W'(1);
            end
         end
         SWITCH: begin
            valid_nxt = 1'b0;
            if (pick_any) begin
               state_nxt = GRANT;
               gnt_nxt   = onehot(pick_idx);
               sel_nxt   = pick_idx;
               cnt_nxt   = '0;
            end else begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 multiplexer datapath (data inputs w0..w3, selectors s1/s0, output f). Four requesters compete for the mux. The block grants one requester at a time and drives the selector pair from the winning index. It enforces a bounded hold time and inserts a one-cycle break-before-make gap between grants. It also registers the selected data bit with a valid flag for the downstream consumer.

## Interface
- MAX_HOLD, default 4: maximum GRANT cycles a requester keeps the mux while another request is pending; legal range 1..16.
- CNT_W, default 4: width of the hold counter; must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; one clock, asynchronous active-high reset.
- req  input  4  request lines, req[i] for requester i; level-sensitive.
- w  input  4  mux data inputs, w[i] is w_i of the datapath.
- gnt  output  4  one-hot grant, registered; all-zero outside GRANT.
- s1  output  1  selector MSB, registered.
- s0  output  1  selector LSB, registered; {s1,s0} = granted index.
- f  output  1  registered mux output, w[{s1,s0}] sampled each GRANT cycle.
- valid  output  1  f holds data from the current grant.
- busy  output  1  high in GRANT and SWITCH.

## Operation
- Reset values: gnt=0, {s1,s0}=0, f=0, valid=0, busy=0, state=IDLE, rotating pointer ptr=0, cnt=0.
- Pick function: scan indices ptr, ptr+1, ... (mod 4) and take the first i with req[i]=1. `any` = |req.
- IDLE:
  - If any: go to GRANT. Load gnt=onehot(pick) and {s1,s0}=pick, set cnt=0, busy=1.
  - Else stay. Selectors keep their last value.
- GRANT, with idx the granted index:
  - Every cycle: f<=w[idx], valid<=1.
  - Release when req[idx]=0, or when cnt==MAX_HOLD-1 and (req & ~onehot(idx))!=0. On release: ptr<=idx+1 mod 4, go to SWITCH.
  - Otherwise, if cnt<MAX_HOLD-1, cnt increments. If cnt==MAX_HOLD-1 with no other request, cnt saturates and the grant continues indefinitely.
- SWITCH (exactly one cycle): gnt=0, valid=0, f holds its last value, selectors unchanged, busy=1.
  - Next state: GRANT with a new pick (using the updated ptr) if any, else IDLE with busy=0.
- gnt, {s1,s0} and busy change only on state-transition edges. The selector never changes while any gnt bit is high.
- Requester drop and hold expiry in the same cycle: a single release, one SWITCH.
- Reset asserted mid-GRANT: all outputs go to reset values immediately (asynchronously). After rst deasserts, arbitration restarts from ptr=0.

## Timing
- req[i] rising in IDLE at edge n: gnt[i] and selectors valid after edge n+1. First valid=1 with f=w[i] after edge n+2.
- Data latency: f reflects w sampled one edge earlier (1-cycle registered).
- Hand-off: the last GRANT cycle of A, then 1 SWITCH cycle, then gnt for B. Gap between consecutive grants = 1 cycle with valid=0.
- Contended tenure: exactly MAX_HOLD GRANT cycles per requester.

## Structure
- Shared package mux_arb_pkg:
  - state encoding IDLE=2'd0, GRANT=2'd1, SWITCH=2'd2;
  - constants NUM_REQ=4, SEL_W=2.
- Sub-module rr_pick4: combinational, inputs (req[3:0], ptr[1:0]), outputs (idx[1:0], any). Instantiated once.
- Top holds the FSM, ptr, cnt and the output registers.

## Test plan
- Single requester: req=4'b0100, w=4'b0100, MAX_HOLD=4 → gnt=4'b0100 and {s1,s0}=2'b10 one edge later; valid=1 and f=1 the edge after; the grant persists while req holds.
- Full contention: req=4'b1111 from reset → grant order 0,1,2,3,0. Each tenure is 4 GRANT cycles followed by 1 SWITCH with gnt=0 and valid=0.
- Early release: grant 1 active, drop req[1] after 2 cycles with req[3]=1 → SWITCH next, then gnt=4'b1000; ptr=2 (2 is skipped because it is not requesting).
- Selector sweep: w=4'b1010, requesters granted in turn → f sequence 0,1,0,1 for indices 0..3, matching the mux truth table.
- Boundary MAX_HOLD=1 with req=4'b0011: alternating gnt 0001, SWITCH, 0010, SWITCH; simultaneous drop and expiry yields exactly one SWITCH.
- Reset mid-GRANT: assert rst while gnt=4'b0010 → gnt, selectors, f, valid and busy are 0 before the next clock edge; after release with req=4'b0010, the first grant goes to requester 1 (scan from ptr=0).
